ultrasonic_echo_responder: RTL and testbench
============================================

ULTRASONIC_ECHO_RESPONDER -- requirements
Module: ultrasonic_echo_responder

Interface
REQ-001 Parameter TRIG_MIN_CYC, default 120: minimum valid trigger width in clk cycles (10 us at 12 MHz).
REQ-002 Parameter SETTLE_CYC, default 2400: trigger-end to echo-rise delay in cycles (8-pulse 40 kHz burst, 200 us).
REQ-003 Parameter TICKS_PER_UNIT, default 696: echo cycles per distance unit (1 cm round trip, 58 us).
REQ-004 Parameter ECHO_MAX, default 456000: maximum echo width in cycles (38 ms, no-object width).
REQ-005 Parameter HOLDOFF_CYC, default 120000: post-echo dead time in cycles (10 ms).
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 trig  input  1  asynchronous trigger pulse from the initiator.
REQ-009 distance  input  16  emulated target distance in units; 0 means no object.
REQ-010 echo  output  1  echo pulse; width encodes distance.
REQ-011 busy  output  1  high while a measurement or its holdoff is in progress.
REQ-012 trig_err  output  1  one-cycle pulse flagging a too-short trigger.

Function
REQ-013 trig SHALL pass through a 2-flop synchronizer; trig_s is the second flop's output, and all trigger decisions SHALL use trig_s only.
REQ-014 FSM states SHALL be IDLE, TRIG, BURST, ECHO, HOLDOFF.
REQ-015 IDLE: trig_s=1 -> TRIG, with the width counter set to 1.
REQ-016 TRIG: count consecutive trig_s=1 cycles, saturating at TRIG_MIN_CYC.
REQ-017 TRIG, trig_s falls with count >= TRIG_MIN_CYC -> BURST; on that edge latch distance and compute echo width.
REQ-018 TRIG, trig_s falls with count < TRIG_MIN_CYC -> IDLE; trig_err SHALL be high for exactly the next cycle.
REQ-019 Trigger upper width is unbounded; trig held high keeps the FSM in TRIG.
REQ-020 Echo width W SHALL be the 32-bit product distance*TICKS_PER_UNIT, clamped to ECHO_MAX; distance=0 SHALL give W=ECHO_MAX.
REQ-021 BURST SHALL last exactly SETTLE_CYC cycles, then -> ECHO.
REQ-022 ECHO: echo=1 for exactly W cycles, then -> HOLDOFF.
REQ-023 echo SHALL be driven from a register and SHALL be glitch-free.
REQ-024 HOLDOFF SHALL last exactly HOLDOFF_CYC cycles, then -> IDLE.
REQ-025 trig activity in BURST, ECHO and HOLDOFF SHALL be ignored.
REQ-026 After HOLDOFF, if trig_s is still high, TRIG SHALL be entered only after trig_s has been seen low in IDLE; no partial-pulse capture.
REQ-027 busy SHALL be 1 in BURST, ECHO and HOLDOFF, and 0 in IDLE and TRIG.
REQ-028 Changes on distance after the latch edge SHALL NOT affect the current echo.
REQ-029 The shared phase counter SHALL be 24 bits wide, and every parameter SHALL fit in 24 bits.

Reset
REQ-030 reset=0 SHALL asynchronously force IDLE, zero all counters and synchronizer flops, and set echo=0, busy=0, trig_err=0.
REQ-031 Reset asserted mid-ECHO SHALL drop echo in the same instant, with no completion of the pulse.
REQ-032 After reset release, the first trig SHALL be handled as a fresh trigger.

Verification
REQ-033 trig high 120 cycles, distance=10 -> echo rises SETTLE_CYC+3 edges after the first edge sampling trig=0, stays high 6960 cycles; busy falls 120000 cycles after echo falls.
REQ-034 trig high 119 cycles -> a single one-cycle trig_err pulse; echo and busy stay 0.
REQ-035 distance=0, valid trigger -> echo width 456000 cycles.
REQ-036 distance=1000, valid trigger (product 696000) -> echo width clamped to 456000.
REQ-037 Second valid trig during HOLDOFF -> ignored and no second echo; trig after busy falls -> normal echo.
REQ-038 reset=0 at cycle 3000 of ECHO, distance=10 -> echo=0 immediately; after release, with no trig, echo stays 0.

Source files
------------

// File: rtl/ultrasonic_echo_responder_if.sv
// Trigger/echo signal bundle between an initiator (master) and the
// ultrasonic echo responder (slave).
interface ultrasonic_echo_responder_if;
  logic        trig;
  logic [15:0] distance;
  logic        echo;
  logic        busy;
  logic        trig_err;

  modport master (
    output trig,
    output distance,
    input  echo,
    input  busy,
    input  trig_err
  );

  modport slave (
    input  trig,
    input  distance,
    output echo,
    output busy,
    output trig_err
  );
endinterface

// File: rtl/ultrasonic_echo_responder.sv
// Emulates an ultrasonic ranging sensor: a qualified trigger pulse is answered,
// after a fixed burst delay, by an echo pulse whose width encodes distance.
module ultrasonic_echo_responder #(
  parameter int unsigned TRIG_MIN_CYC   = 120,
  parameter int unsigned SETTLE_CYC     = 2400,
  parameter int unsigned TICKS_PER_UNIT = 696,
  parameter int unsigned ECHO_MAX       = 456000,
  parameter int unsigned HOLDOFF_CYC    = 120000
) (
  input  logic                         clk,
  input  logic                         reset,
  ultrasonic_echo_responder_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    BURST,
    ECHO,
    HOLDOFF
  } state_e;

  localparam logic [23:0] TRIG_MIN_L = 24'(TRIG_MIN_CYC);
  localparam logic [23:0] SETTLE_L   = 24'(SETTLE_CYC);
  localparam logic [23:0] ECHO_MAX_L = 24'(ECHO_MAX);
  localparam logic [23:0] HOLDOFF_L  = 24'(HOLDOFF_CYC);

  logic        trig_meta_q;
  logic        trig_s_q;
  state_e      state_q,    state_d;
  logic [23:0] cnt_q,      cnt_d;
  logic [23:0] width_q,    width_d;
  logic        need_low_q, need_low_d;
  logic        trig_err_q, trig_err_d;
  logic        echo_q,     echo_d;
  logic        busy_q,     busy_d;
  logic [31:0] product;
  logic [23:0] width_calc;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source; blocking here would collapse the sync chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_meta_q <= 1'b0;
      trig_s_q    <= 1'b0;
    end else begin
      trig_meta_q <= bus.trig;
      trig_s_q    <= trig_meta_q;
    end
  end

  // Distance 0 means no object, which reports the same width as out of range.
  always_comb begin
    product = 32'(bus.distance) * TICKS_PER_UNIT;
    if (bus.distance == 16'd0 || product > ECHO_MAX) begin
      width_calc = ECHO_MAX_L;
    end else begin
      width_calc = 24'(product);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      width_q    <= '0;
      need_low_q <= 1'b0;
      trig_err_q <= 1'b0;
      echo_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      width_q    <= width_d;
      need_low_q <= need_low_d;
      trig_err_q <= trig_err_d;
      echo_q     <= echo_d;
      busy_q     <= busy_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    width_d    = width_q;
    need_low_d = need_low_q;
    trig_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!trig_s_q) begin
          need_low_d = 1'b0;
        end else if (!need_low_q) begin
          state_d = TRIG;
          cnt_d   = 24'd1;
        end
      end

      TRIG: begin
        if (trig_s_q) begin
          if (cnt_q < TRIG_MIN_L) cnt_d = cnt_q + 24'd1;
        end else if (cnt_q >= TRIG_MIN_L) begin
          state_d = BURST;
          cnt_d   = 24'd1;
          width_d = width_calc;
        end else begin
          state_d    = IDLE;
          cnt_d      = '0;
          trig_err_d = 1'b1;
        end
      end

      BURST: begin
        if (cnt_q >= SETTLE_L) begin
          state_d = ECHO;
          cnt_d   = 24'd1;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end

      ECHO: begin
        if (cnt_q >= width_q) begin
          state_d = HOLDOFF;
          cnt_d   = 24'd1;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end

      // A trigger still high when the dead time ends must drop before re-arming.
      HOLDOFF: begin
        if (cnt_q >= HOLDOFF_L) begin
          state_d    = IDLE;
          cnt_d      = '0;
          need_low_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    echo_d = (state_q == ECHO);
    busy_d = (state_q == BURST) || (state_q == ECHO) || (state_q == HOLDOFF);
  end

  assign bus.echo     = echo_q;
  assign bus.busy     = busy_q;
  assign bus.trig_err = trig_err_q;

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Randomized bench for ultrasonic_echo_responder: each trigger is scored against
// a transaction-level model of pulse timing, echo width, holdoff and error pulses.
module tb_ultrasonic_echo_responder;

  localparam int TMIN = 8;
  localparam int S    = 20;
  localparam int T    = 3;
  localparam int EMAX = 100;
  localparam int H    = 50;
  localparam int WIN  = 400;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  int rise_off, echo_fall_off, busy_fall_off;
  int echo_pulses, echo_high, busy_high, err_pulses, err_high;

  always #5 clk = ~clk;

  ultrasonic_echo_responder_if bus ();

  ultrasonic_echo_responder #(
    .TRIG_MIN_CYC  (TMIN),
    .SETTLE_CYC    (S),
    .TICKS_PER_UNIT(T),
    .ECHO_MAX      (EMAX),
    .HOLDOFF_CYC   (H)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_width(input int d);
    int p;
    p = d * T;
    if (d == 0 || p > EMAX) return EMAX;
    return p;
  endfunction

  // Watches a fixed window after the trigger falls; offsets count negedges from then.
  task automatic watch(input int inj_off, input int inj_len);
    logic pe, pb, perr;
    rise_off = -1; echo_fall_off = -1; busy_fall_off = -1;
    echo_pulses = 0; echo_high = 0; busy_high = 0; err_pulses = 0; err_high = 0;
    pe = bus.echo; pb = bus.busy; perr = bus.trig_err;
    for (int i = 1; i <= WIN; i++) begin
      @(negedge clk);
      if (i == 5) bus.distance = 16'($urandom);
      if (inj_off >= 0 && i == inj_off) bus.trig = 1'b1;
      if (inj_off >= 0 && i == inj_off + inj_len) bus.trig = 1'b0;
      if (bus.echo && !pe) begin
        echo_pulses++;
        if (rise_off < 0) rise_off = i;
      end
      if (!bus.echo && pe && echo_fall_off < 0) echo_fall_off = i;
      if (!bus.busy && pb && busy_fall_off < 0) busy_fall_off = i;
      if (bus.echo) echo_high++;
      if (bus.busy) busy_high++;
      if (bus.trig_err && !perr) err_pulses++;
      if (bus.trig_err) err_high++;
      pe = bus.echo; pb = bus.busy; perr = bus.trig_err;
    end
  endtask

  task automatic pulse(input int n, input int d);
    bus.distance = 16'(d);
    @(negedge clk);
    bus.trig = 1'b1;
    repeat (n) @(negedge clk);
    bus.trig = 1'b0;
  endtask

  task automatic run_trig(input int n, input int d, input int inj_off, input int inj_len);
    int w;
    pulse(n, d);
    watch(inj_off, inj_len);
    if (n >= TMIN) begin
      w = exp_width(d);
      check("echo_rise",  rise_off, S + 4);
      check("echo_width", echo_high, w);
      check("echo_count", echo_pulses, 1);
      check("holdoff",    busy_fall_off - echo_fall_off, H);
      check("busy_len",   busy_high, S + w + H);
      check("no_err",     err_high, 0);
    end else begin
      check("err_pulses", err_pulses, 1);
      check("err_width",  err_high, 1);
      check("short_echo", echo_high, 0);
      check("short_busy", busy_high, 0);
    end
  endtask

  initial begin
    reset        = 1'b0;
    bus.trig     = 1'b0;
    bus.distance = '0;
    repeat (3) @(negedge clk);
    check("rst_echo",  bus.echo, 0);
    check("rst_busy",  bus.busy, 0);
    check("rst_err",   bus.trig_err, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_trig(TMIN,     10,   -1, 0);
    run_trig(TMIN - 1, 10,   -1, 0);
    run_trig(TMIN,     0,    -1, 0);
    run_trig(TMIN,     1000, -1, 0);
    run_trig(TMIN,     1,    -1, 0);
    run_trig(60,       20,   -1, 0);
    run_trig(TMIN,     10,   S + 4 + exp_width(10) + 5, 10);
    run_trig(TMIN,     10,   S + 4 + exp_width(10) + 5, H + 30);
    run_trig(TMIN + 1, 12,   -1, 0);

    for (int k = 0; k < 12; k++) begin
      run_trig(int'($urandom_range(TMIN + 12, 1)), int'($urandom_range(45, 0)), -1, 0);
    end

    pulse(TMIN, 30);
    repeat (S + 44) @(negedge clk);
    check("mid_echo", bus.echo, 1);
    #2 reset = 1'b0;
    #1;
    check("rst_drop_echo", bus.echo, 0);
    check("rst_drop_busy", bus.busy, 0);
    @(negedge clk);
    reset = 1'b1;
    watch(-1, 0);
    check("post_rst_echo", echo_high, 0);
    check("post_rst_busy", busy_high, 0);
    check("post_rst_err",  err_high, 0);

    run_trig(TMIN, 7, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
